// File: rtl/pc_fetch.sv
// Instruction fetch stage: BOOT/RUN/HALT sequencer, PC register and IF/ID register.
// Optional jump predecode enabled by defining FETCH_JUMP_PREDECODE_EN.
module pc_fetch #(
  parameter int DEPTH = 16
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] pc_out,
  input  logic [31:0] inst,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_inst,
  output logic [31:0] id_pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic        halted,
  output logic        fetch_err,
  output logic [15:0] fetch_count
);
  localparam logic [31:0] DEPTH_W = 32'(DEPTH);

  typedef enum logic [1:0] {BOOT, RUN, HALT} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        id_valid_q, id_valid_d;
  logic [31:0] id_inst_q, id_inst_d;
  logic [31:0] id_pc_q, id_pc_d;
  logic        fetch_err_q, fetch_err_d;
  logic [15:0] fetch_count_q, fetch_count_d;

  logic        is_jmp;
  logic [31:0] jmp_tgt, next_pc;

  always_comb begin
    is_jmp  = 1'b0;
    jmp_tgt = {4'b0, inst[25:0], 2'b00};
`ifdef FETCH_JUMP_PREDECODE_EN
    is_jmp  = (inst[31:26] == 6'b000010);
`else
    is_jmp  = 1'b0;
`endif
    next_pc = is_jmp ? jmp_tgt : pc_q + 32'd1;
  end

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    id_valid_d    = id_valid_q;
    id_inst_d     = id_inst_q;
    id_pc_d       = id_pc_q;
    fetch_err_d   = fetch_err_q;
    fetch_count_d = fetch_count_q;
    case (state_q)
      BOOT: state_d = RUN;
      default: begin
        if (redirect_valid) begin
          // Redirect flushes IF/ID; an out-of-range target parks the stage.
          id_valid_d = 1'b0;
          if (redirect_target < DEPTH_W) begin
            pc_d    = redirect_target;
            state_d = RUN;
          end else begin
            fetch_err_d = 1'b1;
            state_d     = HALT;
          end
        end else if (state_q == HALT) begin
          if (id_ready) id_valid_d = 1'b0;
        end else if (!id_valid_q || id_ready) begin
          id_inst_d  = inst;
          id_pc_d    = pc_q;
          id_valid_d = 1'b1;
          if (fetch_count_q != 16'hFFFF) fetch_count_d = fetch_count_q + 16'd1;
          // Running off the end holds pc on the last word instead of wrapping.
          if (next_pc >= DEPTH_W) begin
            state_d = HALT;
            if (is_jmp) fetch_err_d = 1'b1;
          end else begin
            pc_d = next_pc;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= BOOT;
      pc_q          <= '0;
      id_valid_q    <= 1'b0;
      id_inst_q     <= '0;
      id_pc_q       <= '0;
      fetch_err_q   <= 1'b0;
      fetch_count_q <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      id_valid_q    <= id_valid_d;
      id_inst_q     <= id_inst_d;
      id_pc_q       <= id_pc_d;
      fetch_err_q   <= fetch_err_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  assign pc_out      = pc_q;
  assign id_valid    = id_valid_q;
  assign id_inst     = id_inst_q;
  assign id_pc       = id_pc_q;
  assign halted      = (state_q == HALT);
  assign fetch_err   = fetch_err_q;
  assign fetch_count = fetch_count_q;
endmodule

// File: tb/tb_pc_fetch.sv
// Bench for pc_fetch: directed scenarios plus randomized traffic against a
// cycle-level behavioural model of the fetch rules.
module tb_pc_fetch;
  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] pc_out, inst, id_inst, id_pc, redirect_target;
  logic        id_valid, id_ready, redirect_valid, halted, fetch_err;
  logic [15:0] fetch_count;

  pc_fetch #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .pc_out(pc_out), .inst(inst),
    .id_valid(id_valid), .id_ready(id_ready), .id_inst(id_inst), .id_pc(id_pc),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .halted(halted), .fetch_err(fetch_err), .fetch_count(fetch_count)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [0:DEPTH-1];
  assign inst = (pc_out < 32'(DEPTH)) ? mem[pc_out[3:0]] : 32'h0;

  int n_tests = 0;
  int n_fail  = 0;

  // Model: mode 0 = boot, 1 = running, 2 = halted
  int          m_mode;
  logic [31:0] m_pc, m_inst, m_idpc;
  logic        m_idv, m_err;
  logic [15:0] m_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_pc = 0; m_inst = 0; m_idpc = 0; m_idv = 0; m_err = 0; m_cnt = 0;
  endtask

  task automatic model_edge(input logic rv, input logic [31:0] rt, input logic rdy);
    logic [31:0] ins, np;
    bit jmp;
    if (m_mode == 0) m_mode = 1;
    else if (rv) begin
      m_idv = 0;
      if (rt < DEPTH) begin m_pc = rt; m_mode = 1; end
      else begin m_err = 1; m_mode = 2; end
    end else if (m_mode == 2) begin
      if (rdy) m_idv = 0;
    end else if (!m_idv || rdy) begin
      ins = mem[m_pc];
      m_inst = ins; m_idpc = m_pc; m_idv = 1;
      if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 1;
      jmp = 0;
`ifdef FETCH_JUMP_PREDECODE_EN
      jmp = (ins[31:26] == 6'b000010);
`endif
      np = jmp ? {4'b0, ins[25:0], 2'b00} : m_pc + 1;
      if (np >= DEPTH) begin m_mode = 2; if (jmp) m_err = 1; end
      else m_pc = np;
    end
  endtask

  task automatic step();
    model_edge(redirect_valid, redirect_target, id_ready);
    @(posedge clk); #1;
    chk("pc_out", pc_out, m_pc);
    chk("id_valid", 32'(id_valid), 32'(m_idv));
    if (m_idv) begin
      chk("id_inst", id_inst, m_inst);
      chk("id_pc", id_pc, m_idpc);
    end
    chk("halted", 32'(halted), 32'(m_mode == 2));
    chk("fetch_err", 32'(fetch_err), 32'(m_err));
    chk("fetch_count", 32'(fetch_count), 32'(m_cnt));
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_pc"}, pc_out, 0);
    chk({tag, "_idv"}, 32'(id_valid), 0);
    chk({tag, "_inst"}, id_inst, 0);
    chk({tag, "_idpc"}, id_pc, 0);
    chk({tag, "_halt"}, 32'(halted), 0);
    chk({tag, "_err"}, 32'(fetch_err), 0);
    chk({tag, "_cnt"}, 32'(fetch_count), 0);
  endtask

  initial begin
    logic [15:0] c0;
    logic [31:0] r;
    for (int i = 0; i < DEPTH; i++) mem[i] = 32'h20010001 + (32'(i) << 11);
    mem[10] = 32'h08000003;
    id_ready = 1'b1; redirect_valid = 1'b0; redirect_target = 0;
    model_reset();

    // Reset and boot
    #1 chk_reset_vals("rst");
    @(negedge clk) rst = 1'b1;
    step(); chk("boot_idv", 32'(id_valid), 0);
    step(); chk("first_inst", id_inst, 32'h20010001); chk("first_pc", id_pc, 0);
    for (int i = 1; i <= 5; i++) begin step(); chk("seq_pc", id_pc, 32'(i)); end

    // Stall for three cycles on id_pc=5
    id_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(); chk("stall_idpc", id_pc, 5); chk("stall_pcout", pc_out, 6);
    end
    id_ready = 1'b1;
    step(); chk("post_stall", id_pc, 6);

    // Redirect during a stall
    id_ready = 1'b0;
    step();
    c0 = fetch_count;
    redirect_valid = 1'b1; redirect_target = 2;
    step();
    chk("redir_idv", 32'(id_valid), 0); chk("redir_pc", pc_out, 2);
    chk("redir_cnt", 32'(fetch_count), 32'(c0));
    redirect_valid = 1'b0; id_ready = 1'b1;
    step(); chk("redir_idpc", id_pc, 2);
    for (int i = 3; i <= 9; i++) step();
    chk("pre_jmp", id_pc, 9);
    c0 = fetch_count;
    step(); chk("jmp_pc", id_pc, 10); chk("jmp_cnt", 32'(fetch_count), 32'(c0) + 1);
    c0 = fetch_count;
    step();
`ifdef FETCH_JUMP_PREDECODE_EN
    chk("jmp_tgt", id_pc, 12);
`else
    chk("jmp_plain", id_pc, 11);
`endif
    chk("jmp_cnt2", 32'(fetch_count), 32'(c0) + 1);

    // Run to the end of memory
    for (int i = 0; i < 20 && !halted; i++) step();
    chk("end_halt", 32'(halted), 1); chk("end_idpc", id_pc, 15);
    chk("end_pcout", pc_out, 15); chk("end_idv", 32'(id_valid), 1);
    step(); chk("end_drain", 32'(id_valid), 0); chk("end_halt2", 32'(halted), 1);
    redirect_valid = 1'b1; redirect_target = 20;
    step(); chk("oor_err", 32'(fetch_err), 1); chk("oor_halt", 32'(halted), 1);
    redirect_target = 3;
    step(); chk("resume", 32'(halted), 0); chk("resume_pc", pc_out, 3);
    redirect_valid = 1'b0;
    step(); step();
    id_ready = 1'b0;
    step();

    // Asynchronous reset mid-stall
    #2 rst = 1'b0;
    #1 chk_reset_vals("arst");
    model_reset();
    id_ready = 1'b1;
    @(negedge clk) rst = 1'b1;
    step(); chk("arst_boot", 32'(id_valid), 0);
    step(); chk("arst_first", id_pc, 0);

    // Randomized traffic with jumps sprinkled into memory
    for (int i = 0; i < DEPTH; i++) begin
      r = $urandom();
      if ($urandom_range(0, 4) == 0) mem[i] = {6'b000010, 26'($urandom_range(0, 5))};
      else mem[i] = {6'b001000, r[25:0]};
    end
    for (int n = 0; n < 400; n++) begin
      id_ready        = ($urandom_range(0, 9) < 7);
      redirect_valid  = ($urandom_range(0, 19) == 0);
      redirect_target = 32'($urandom_range(0, 23));
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
